bp_be_late_wb_arbiter: RTL and testbench

//   Shares the single late-writeback port of the int/fp register files between late producers
//   (req 0: D$ load-miss refill, req 1: long pipe idiv/fdiv). Each requester gets a small FIFO.

---
 rtl/bp_be_late_wb_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_bp_be_late_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: one small FIFO per late producer feeding the shared int/fp register
// file write port through a round-robin grant that is held stable while the port is busy.

module bp_be_late_wb_fifo #(
    parameter int els_p   = 2,
    parameter int width_p = 70
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p) + 1;
    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

    logic [els_p-1:0][width_p-1:0] mem_r;
    logic [ptr_w_lp-1:0]           wptr_r, rptr_r;
    logic [cnt_w_lp-1:0]           count_r;
    logic                          push, pop;

    // Ready comes from the registered count only: a full FIFO refuses even when popping.
    assign ready_o = (count_r < full_lp);
    assign v_o     = (count_r != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = mem_r[rptr_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) wptr_r <= wptr_r + ptr_one_lp;
            if (pop)  rptr_r <= rptr_r + ptr_one_lp;
            case ({push, pop})
                2'b10:   count_r <= count_r + cnt_one_lp;
                2'b01:   count_r <= count_r - cnt_one_lp;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is not reset; every reader qualifies the head with v_o.
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wptr_r] <= data_i;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push && (count_r == full_lp)));
    a_pop_nonempty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o);
    a_v_known: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !$isunknown(v_i));
endmodule

module bp_be_late_wb_arbiter #(
    parameter int  num_req_p        = 2,
    parameter int  fifo_els_p       = 2,
    parameter int  data_width_p     = 64,
    parameter int  reg_addr_width_p = 5,
    localparam int src_w_lp         = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    output logic [num_req_p-1:0]                  req_ready_o,
    input  logic [num_req_p-1:0]                  req_frf_i,
    input  logic [num_req_p*reg_addr_width_p-1:0] req_rd_i,
    input  logic [num_req_p*data_width_p-1:0]     req_data_i,
    output logic                                  wb_v_o,
    input  logic                                  wb_ready_i,
    output logic                                  wb_frf_o,
    output logic [reg_addr_width_p-1:0]           wb_rd_o,
    output logic [data_width_p-1:0]               wb_data_o,
    output logic [src_w_lp-1:0]                   wb_src_o,
    output logic                                  idle_o
);
    typedef struct packed {
        logic                        frf;
        logic [reg_addr_width_p-1:0] rd;
        logic [data_width_p-1:0]     data;
    } wb_entry_s;

    localparam int entry_w_lp = $bits(wb_entry_s);
    localparam logic [src_w_lp-1:0] last_src_lp = src_w_lp'(num_req_p - 1);
    localparam logic [src_w_lp-1:0] src_one_lp  = src_w_lp'(1);

    typedef enum logic {e_idle, e_hold} state_e;

    logic [num_req_p-1:0][entry_w_lp-1:0] enq, head;
    logic [num_req_p-1:0]                 head_v, pop_v;

    state_e              state_r, state_n;
    logic [src_w_lp-1:0] rr_r, rr_n, grant_r, grant_n;
    logic [src_w_lp-1:0] sel_idx, cur_grant, grant_inc;
    logic                sel_found, wb_v, fire;
    wb_entry_s           head_sel;
    int                  idx;

    for (genvar k = 0; k < num_req_p; k++) begin : g_enq
        assign enq[k] = {req_frf_i[k],
                         req_rd_i[k*reg_addr_width_p +: reg_addr_width_p],
                         req_data_i[k*data_width_p +: data_width_p]};
    end

    bp_be_late_wb_fifo #(
        .els_p  (fifo_els_p),
        .width_p(entry_w_lp)
    ) fifo [num_req_p-1:0] (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (req_v_i),
        .data_i   (enq),
        .ready_o  (req_ready_o),
        .yumi_i   (pop_v),
        .v_o      (head_v),
        .data_o   (head)
    );

    // First non-empty FIFO at or after the rr pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_r;
        idx       = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_r) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!sel_found && head_v[idx]) begin
                sel_found = 1'b1;
                sel_idx   = src_w_lp'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            rr_r    <= '0;
            grant_r <= '0;
        end else begin
            state_r <= state_n;
            rr_r    <= rr_n;
            grant_r <= grant_n;
        end
    end

    assign grant_inc = (cur_grant == last_src_lp) ? '0 : cur_grant + src_one_lp;

    always_comb begin
        state_n = state_r;
        rr_n    = rr_r;
        grant_n = grant_r;
        unique case (state_r)
            e_idle: begin
                if (sel_found) begin
                    if (wb_ready_i) begin
                        rr_n = grant_inc;
                    end else begin
                        grant_n = sel_idx;
                        state_n = e_hold;
                    end
                end
            end
            e_hold: begin
                if (wb_ready_i) begin
                    rr_n    = grant_inc;
                    state_n = e_idle;
                end
            end
        endcase
    end

    // A held grant ignores newer arrivals so the port sees stable data until accepted.
    always_comb begin
        cur_grant = (state_r == e_hold) ? grant_r : sel_idx;
        wb_v      = (state_r == e_hold) | sel_found;
        fire      = wb_v & wb_ready_i;
        pop_v     = '0;
        if (fire) pop_v[cur_grant] = 1'b1;
        head_sel  = head[cur_grant];
        wb_v_o    = wb_v;
        wb_frf_o  = wb_v ? head_sel.frf  : 1'b0;
        wb_rd_o   = wb_v ? head_sel.rd   : '0;
        wb_data_o = wb_v ? head_sel.data : '0;
        wb_src_o  = wb_v ? cur_grant     : '0;
    end

    assign idle_o = ~|head_v & (state_r == e_idle);

    a_hold_nonempty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == e_hold) |-> head_v[grant_r]);
endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Bench for bp_be_late_wb_arbiter: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of the arbitration rules.

module tb_bp_be_late_wb_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_v = '0, req_frf = '0, req_ready;
    logic [9:0]   req_rd = '0;
    logic [127:0] req_data = '0;
    logic         wb_v, wb_ready = 1'b0, wb_frf, idle;
    logic [4:0]   wb_rd;
    logic [63:0]  wb_data;
    logic [0:0]   wb_src;

    always #5 clk = ~clk;

    bp_be_late_wb_arbiter dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(req_v), .req_ready_o(req_ready), .req_frf_i(req_frf),
        .req_rd_i(req_rd), .req_data_i(req_data),
        .wb_v_o(wb_v), .wb_ready_i(wb_ready), .wb_frf_o(wb_frf), .wb_rd_o(wb_rd),
        .wb_data_o(wb_data), .wb_src_o(wb_src), .idle_o(idle)
    );

    typedef struct packed { logic frf; logic [4:0] rd; logic [63:0] data; } ent_t;
    typedef struct packed {
        logic v; logic src; logic frf; logic [4:0] rd; logic [63:0] data;
        logic [1:0] rdy; logic idle;
    } obs_t;

    ent_t q0[$], q1[$];
    int   rr, held;
    int   n_checks = 0, n_err = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o = '{v: wb_v, src: wb_src[0], frf: wb_frf, rd: wb_rd, data: wb_data,
              rdy: req_ready, idle: idle};
        return o;
    endfunction

    function automatic int qsz(int k);
        return (k == 1) ? q1.size() : q0.size();
    endfunction

    // Expected outputs from the queue contents, the rr pointer and any held grant.
    function automatic obs_t model_obs();
        obs_t e;
        ent_t h;
        int   g;
        e = '0;
        g = -1;
        if (held >= 0) g = held;
        else for (int i = 0; i < 2; i++) if (g < 0 && qsz((rr + i) % 2) > 0) g = (rr + i) % 2;
        if (g >= 0) begin
            h = (g == 1) ? q1[0] : q0[0];
            e.v = 1'b1; e.src = (g == 1); e.frf = h.frf; e.rd = h.rd; e.data = h.data;
        end
        e.rdy[0] = (q0.size() < 2);
        e.rdy[1] = (q1.size() < 2);
        e.idle   = (q0.size() == 0) && (q1.size() == 0) && (held < 0);
        return e;
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete(); rr = 0; held = -1;
    endtask

    task automatic advance();
        obs_t e;
        e = model_obs();
        @(posedge clk);
        if (e.v) begin
            if (wb_ready) begin
                if (e.src) void'(q1.pop_front()); else void'(q0.pop_front());
                rr = (int'(e.src) + 1) % 2;
                held = -1;
            end else held = int'(e.src);
        end
        if (req_v[0] && e.rdy[0]) q0.push_back('{frf: req_frf[0], rd: req_rd[4:0], data: req_data[63:0]});
        if (req_v[1] && e.rdy[1]) q1.push_back('{frf: req_frf[1], rd: req_rd[9:5], data: req_data[127:64]});
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o, e;
        model_reset();
        #1;
        o = dut_obs(); e = model_obs(); n_checks++;
        if (o !== e) begin n_err++; $display("FAIL reset_model: got %h expected %h", o, e); end
        n_checks++;
        if (req_ready !== 2'b11 || wb_v !== 1'b0 || idle !== 1'b1 || wb_data !== 64'd0) begin
            n_err++; $display("FAIL reset_state: got rdy=%b v=%b idle=%b data=%h", req_ready, wb_v, idle, wb_data);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        obs_t o, e;
        logic exp_src;
        wb_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v = 2'b11; req_frf = 2'b00; req_rd = {5'(10 + i), 5'(i)};
            req_data = {64'h1000 + 64'(i), 64'h2000 + 64'(i)};
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL rr_fill step %0d: got %h expected %h", i, o, e); end
            advance();
        end
        req_v = 2'b00; wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL rr_drain step %0d: got %h expected %h", i, o, e); end
            exp_src = 1'(i % 2);
            n_checks++;
            if (i < 4 && (wb_v !== 1'b1 || wb_src[0] !== exp_src)) begin
                n_err++; $display("FAIL rr_seq step %0d: got v=%b src=%b expected v=1 src=%b", i, wb_v, wb_src, exp_src);
            end else if (i == 4 && wb_v !== 1'b0) begin
                n_err++; $display("FAIL rr_end: got v=%b expected 0", wb_v);
            end
            advance();
        end
    endtask

    task automatic test_single();
        obs_t o, e;
        wb_ready = 1'b1; req_v = 2'b01; req_frf = 2'b00; req_rd = {5'd0, 5'd5};
        req_data = {64'd0, 64'hAB};
        #1; o = dut_obs(); e = model_obs(); n_checks++;
        if (o !== e) begin n_err++; $display("FAIL single_push: got %h expected %h", o, e); end
        advance();
        req_v = 2'b00;
        #1; n_checks++;
        if (wb_v !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'hAB || wb_src !== 1'b0 || wb_frf !== 1'b0) begin
            n_err++; $display("FAIL single_wb: got v=%b rd=%0d data=%h src=%b expected v=1 rd=5 data=ab src=0", wb_v, wb_rd, wb_data, wb_src);
        end
        advance();
        #1; n_checks++;
        if (wb_v !== 1'b0 || idle !== 1'b1) begin
            n_err++; $display("FAIL single_done: got v=%b idle=%b expected v=0 idle=1", wb_v, idle);
        end
    endtask

    task automatic test_hold();
        obs_t o, e;
        wb_ready = 1'b0; req_v = 2'b10; req_frf = 2'b00; req_rd = {5'd7, 5'd0};
        req_data = {64'h1111, 64'h0};
        #1; advance();
        for (int i = 0; i < 3; i++) begin
            req_v = 2'b01; req_rd = {5'd0, 5'(20 + i)}; req_data = {64'h0, 64'h5500 + 64'(i)};
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL hold_model step %0d: got %h expected %h", i, o, e); end
            n_checks++;
            if (wb_v !== 1'b1 || wb_src !== 1'b1 || wb_data !== 64'h1111) begin
                n_err++; $display("FAIL hold_stable step %0d: got v=%b src=%b data=%h expected v=1 src=1 data=1111", i, wb_v, wb_src, wb_data);
            end
            advance();
        end
        req_v = 2'b00; wb_ready = 1'b1;
        #1; advance();
        #1; n_checks++;
        if (wb_v !== 1'b1 || wb_src !== 1'b0) begin
            n_err++; $display("FAIL hold_next: got v=%b src=%b expected v=1 src=0", wb_v, wb_src);
        end
        for (int i = 0; i < 3; i++) begin
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL hold_drain step %0d: got %h expected %h", i, o, e); end
            advance();
        end
    endtask

    task automatic test_full();
        obs_t o, e;
        wb_ready = 1'b0; req_frf = 2'b00;
        for (int i = 0; i < 3; i++) begin
            req_v = 2'b01; req_rd = {5'd0, 5'(i + 1)}; req_data = {64'h0, 64'hD0 + 64'(i)};
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL full_fill step %0d: got %h expected %h", i, o, e); end
            if (i == 2) begin
                n_checks++;
                if (req_ready[0] !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", req_ready[0]); end
            end
            advance();
        end
        wb_ready = 1'b1;
        #1; o = dut_obs(); e = model_obs(); n_checks++;
        if (o !== e) begin n_err++; $display("FAIL full_pop: got %h expected %h", o, e); end
        advance();
        wb_ready = 1'b0;
        #1; n_checks++;
        if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL full_reopen: got %b expected 1", req_ready[0]); end
        advance();
        req_v = 2'b00; wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL full_drain step %0d: got %h expected %h", i, o, e); end
            n_checks++;
            if (i < 2 && wb_data !== 64'hD1 + 64'(i)) begin
                n_err++; $display("FAIL full_order step %0d: got %h expected %h", i, wb_data, 64'hD1 + 64'(i));
            end else if (i == 2 && wb_v !== 1'b0) begin
                n_err++; $display("FAIL full_empty: got v=%b expected 0", wb_v);
            end
            advance();
        end
    endtask

    task automatic test_fp();
        wb_ready = 1'b1; req_v = 2'b10; req_frf = 2'b10; req_rd = {5'd31, 5'd0};
        req_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        #1; advance();
        req_v = 2'b00; req_frf = 2'b00;
        #1; n_checks++;
        if (wb_v !== 1'b1 || wb_frf !== 1'b1 || wb_rd !== 5'd31 || wb_data !== 64'hFFFF_FFFF_FFFF_FFFF || wb_src !== 1'b1) begin
            n_err++; $display("FAIL fp_dest: got v=%b frf=%b rd=%0d data=%h src=%b", wb_v, wb_frf, wb_rd, wb_data, wb_src);
        end
        advance();
    endtask

    task automatic test_reset_midstream();
        obs_t o, e;
        wb_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_v = 2'b01; req_rd = {5'd0, 5'(3 + i)}; req_data = {64'h0, 64'hCC + 64'(i)};
            #1; advance();
        end
        req_v = 2'b00;
        rst_n = 1'b0; model_reset();
        #1; o = dut_obs(); e = model_obs(); n_checks++;
        if (o !== e) begin n_err++; $display("FAIL midreset_model: got %h expected %h", o, e); end
        n_checks++;
        if (wb_v !== 1'b0 || idle !== 1'b1 || req_ready !== 2'b11) begin
            n_err++; $display("FAIL midreset_async: got v=%b idle=%b rdy=%b expected 0 1 11", wb_v, idle, req_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        #1; o = dut_obs(); e = model_obs(); n_checks++;
        if (o !== e) begin n_err++; $display("FAIL midreset_release: got %h expected %h", o, e); end
        @(negedge clk);
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int i = 0; i < 400; i++) begin
            req_v = 2'($urandom); req_frf = 2'($urandom); req_rd = 10'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            wb_ready = ($urandom_range(0, 3) != 0);
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL random step %0d: got %h expected %h", i, o, e); end
            advance();
        end
        req_v = 2'b00; wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1; o = dut_obs(); e = model_obs(); n_checks++;
            if (o !== e) begin n_err++; $display("FAIL random_drain step %0d: got %h expected %h", i, o, e); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_hold();
        test_full();
        test_fp();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
